program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader between the host-facing UART and instruction memory. It pulls a length-prefixed program image byte by byte from the UART receive side, packs the bytes little-endian into 32-bit words and writes them to consecutive word addresses of instruction memory. It then raises `load_completed`, which releases core, main memory and UART reset.

## Interface

Parameters:
- `INST_MEM_BIT_WIDTH`, default 16: instruction memory byte-address width. Capacity is 2^INST_MEM_BIT_WIDTH / 4 words.
- `RESET_CYCLES`, default 10: number of cycles `load_reset` is held after reset deasserts.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `uart_out_valid` out 1: byte request to the UART.
- `uart_out_ready` in 1: UART grant; `uart_out_data` is valid in the same cycle.
- `uart_out_data` in 8: received byte.
- `inst_mem_in_addr` out 32: write byte address, always a multiple of 4.
- `inst_mem_in_data` out 32: write data.
- `inst_mem_in_valid` out 1: write request.
- `inst_mem_in_ready` in 1: write accepted.
- `load_reset` out 1: instruction memory reset.
- `load_completed` out 1: image fully written; held until reset.
- `load_error` out 1: length header exceeds capacity; held until reset.
- `checksum` out 32: mod-2^32 sum of all written words.

## Operation

- Image format:
  - Header: 4 bytes, little-endian, giving N = word count.
  - Payload: N×4 bytes. The first byte of each group goes to bits [7:0], the last to bits [31:24].
- FSM states:
  - MEM_RST: `load_reset`=1. A counter counts RESET_CYCLES cycles, then the FSM goes to HDR.
  - HDR: collects 4 bytes into `len`. On the 4th byte:
    - N=0 → DONE.
    - N > 2^INST_MEM_BIT_WIDTH/4 → ERR.
    - Otherwise → DATA.
  - DATA: collects 4 bytes into the word register, then → WRITE.
  - WRITE: drives addr = word_index×4, data = word, valid=1. On `inst_mem_in_ready`=1 at a rising edge:
    - `checksum` += word, word_index += 1.
    - If word_index reached N → DONE, else → DATA.
  - DONE: `load_completed`=1. Terminal.
  - ERR: `load_error`=1, `load_completed`=0. Terminal.
- Byte fetch, in HDR and DATA:
  - Assert `uart_out_valid`. The byte is captured at the rising edge where `uart_out_ready`=1.
  - `uart_out_valid` is low for the following cycle; at least one idle cycle separates consecutive requests.
  - A 2-bit byte counter selects the lane: lane k is written to bits [8k+7:8k]. The counter wraps 3→0.
- `uart_out_ready` arriving while `uart_out_valid`=0 is ignored.
- Write handshake:
  - `inst_mem_in_valid`, `inst_mem_in_addr` and `inst_mem_in_data` are stable from assertion until acceptance.
  - No byte request is issued while in WRITE.
- Width rules:
  - word_index is 32-bit and `len` is 32-bit.
  - The capacity comparison is unsigned on the full 32 bits, so a header of 0xFFFFFFFF → ERR.
  - The address is word_index shifted left by 2, truncated to 32 bits.

## Timing

- Reset values:
  - `load_reset`=1, `load_completed`=0, `load_error`=0.
  - `uart_out_valid`=0, `inst_mem_in_valid`=0.
  - `inst_mem_in_addr`=0, `inst_mem_in_data`=0, `checksum`=0.
  - State is MEM_RST.
- Assertion of `reset` mid-load:
  - Immediately (asynchronously) returns all registers to their reset values.
  - The in-flight write is abandoned.
  - The load restarts with header parsing after MEM_RST.
- `load_reset` falls after exactly RESET_CYCLES rising edges following `reset` deassert. The first `uart_out_valid` is asserted on the next cycle.
- Byte accept to next request: 2 cycles minimum.
- 4th payload byte accepted → `inst_mem_in_valid` high the next cycle.
- Memory returning `inst_mem_in_ready` in the same cycle as valid gives 1 cycle per write.
- Last write accepted → `load_completed` high the next cycle.
- Outputs are registered except `uart_out_valid` and `inst_mem_in_valid`, which are decoded from registered state only.

## Test plan

- **Reset timing:** reset, then count cycles → `load_reset` high for 10 cycles; no `uart_out_valid` before it falls.
- **Two-word image:** feed bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 → writes (0x0, 0x00000013) then (0x4, 0x0000006F); `checksum`=0x82; `load_completed`=1 one cycle after the second write accepts.
- **Zero length:** header 00 00 00 00 → no `inst_mem_in_valid` ever; `load_completed`=1.
- **Oversize header:** header 01 40 00 00 (N=16385 > 16384) → `load_error`=1, `load_completed`=0; no writes and no further byte requests.
- **Backpressure:** `inst_mem_in_ready` low for 5 cycles on the first write → addr/data/valid stable all 5 cycles; no `uart_out_valid` during the stall; the word is written exactly once.
- **Mid-load reset:** `reset` pulsed after the 2nd payload byte → outputs return to reset values within the same cycle; reload with the same image yields the identical write sequence and `checksum`.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: pulls a length-prefixed image from the UART, packs the bytes
// little-endian into 32-bit words and writes them to instruction memory.
module program_loader #(
  parameter int INST_MEM_BIT_WIDTH = 16,
  parameter int RESET_CYCLES       = 10
) (
  input  logic        clk,
  input  logic        reset,
  output logic        uart_out_valid,
  input  logic        uart_out_ready,
  input  logic [7:0]  uart_out_data,
  output logic [31:0] inst_mem_in_addr,
  output logic [31:0] inst_mem_in_data,
  output logic        inst_mem_in_valid,
  input  logic        inst_mem_in_ready,
  output logic        load_reset,
  output logic        load_completed,
  output logic        load_error,
  output logic [31:0] checksum
);
  localparam int          CW       = $clog2(RESET_CYCLES + 1);
  localparam logic [32:0] CAPACITY = 33'd1 << (INST_MEM_BIT_WIDTH - 2);

  typedef enum logic [2:0] {MEM_RST, HDR, DATA, WRITE, DONE, ERR} state_e;

  state_e        state_q;
  logic [CW-1:0] rst_cnt_q;
  logic [1:0]    byte_cnt_q;
  logic          gap_q;
  logic [31:0]   len_q, len_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   word_idx_q;
  logic [31:0]   addr_q, data_q, checksum_q;
  logic          load_reset_q, load_completed_q, load_error_q;
  logic          byte_fire;

  // gap_q forces one idle cycle after every accepted byte.
  assign uart_out_valid    = ((state_q == HDR) || (state_q == DATA)) && !gap_q;
  assign inst_mem_in_valid = (state_q == WRITE);
  assign byte_fire         = uart_out_valid && uart_out_ready;

  assign inst_mem_in_addr = addr_q;
  assign inst_mem_in_data = data_q;
  assign load_reset       = load_reset_q;
  assign load_completed   = load_completed_q;
  assign load_error       = load_error_q;
  assign checksum         = checksum_q;

  always_comb begin
    len_d  = len_q;
    word_d = word_q;
    len_d[8*byte_cnt_q +: 8]  = uart_out_data;
    word_d[8*byte_cnt_q +: 8] = uart_out_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= MEM_RST;
      rst_cnt_q        <= '0;
      byte_cnt_q       <= '0;
      gap_q            <= 1'b0;
      len_q            <= '0;
      word_q           <= '0;
      word_idx_q       <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      checksum_q       <= '0;
      load_reset_q     <= 1'b1;
      load_completed_q <= 1'b0;
      load_error_q     <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      case (state_q)
        MEM_RST: begin
          if (rst_cnt_q == CW'(RESET_CYCLES - 1)) begin
            state_q      <= HDR;
            load_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        HDR: begin
          if (byte_fire) begin
            gap_q      <= 1'b1;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            len_q      <= len_d;
            if (byte_cnt_q == 2'd3) begin
              if (len_d == 32'd0) begin
                state_q          <= DONE;
                load_completed_q <= 1'b1;
              end else if ({1'b0, len_d} > CAPACITY) begin
                state_q      <= ERR;
                load_error_q <= 1'b1;
              end else begin
                state_q <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (byte_fire) begin
            gap_q      <= 1'b1;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= word_d;
            if (byte_cnt_q == 2'd3) begin
              state_q <= WRITE;
              addr_q  <= {word_idx_q[29:0], 2'b00};
              data_q  <= word_d;
            end
          end
        end
        WRITE: begin
          if (inst_mem_in_ready) begin
            checksum_q <= checksum_q + data_q;
            word_idx_q <= word_idx_q + 32'd1;
            if (word_idx_q + 32'd1 == len_q) begin
              state_q          <= DONE;
              load_completed_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: UART/memory responders plus an
// image-level reference model of the expected write stream.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_out_valid, uart_out_ready;
  logic [7:0]  uart_out_data;
  logic [31:0] inst_mem_in_addr, inst_mem_in_data, checksum;
  logic        inst_mem_in_valid, inst_mem_in_ready;
  logic        load_reset, load_completed, load_error;

  program_loader #(.INST_MEM_BIT_WIDTH(16), .RESET_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .uart_out_valid(uart_out_valid), .uart_out_ready(uart_out_ready),
    .uart_out_data(uart_out_data),
    .inst_mem_in_addr(inst_mem_in_addr), .inst_mem_in_data(inst_mem_in_data),
    .inst_mem_in_valid(inst_mem_in_valid), .inst_mem_in_ready(inst_mem_in_ready),
    .load_reset(load_reset), .load_completed(load_completed),
    .load_error(load_error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  img[$];
  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  logic [31:0] exp_sum;
  int exp_kind;  // 0 = completes, 1 = error
  int bidx, stall_left, stop_after, done_cyc, last_wr_cyc;

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    uart_out_ready = 1'b0;
    inst_mem_in_ready = 1'b0;
    #1;
    tests++;
    if ({load_reset, load_completed, load_error, uart_out_valid, inst_mem_in_valid} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=10000",
               {load_reset, load_completed, load_error, uart_out_valid, inst_mem_in_valid});
    end
    tests++;
    if ({inst_mem_in_addr, inst_mem_in_data, checksum} !== 96'd0) begin
      fails++;
      $display("FAIL reset_regs addr=%h data=%h sum=%h exp all 0",
               inst_mem_in_addr, inst_mem_in_data, checksum);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference: decode the image header and payload into the expected write list.
  task automatic build_expected();
    logic [31:0] n, d;
    exp_addr.delete();
    exp_data.delete();
    exp_sum = 32'd0;
    n = {img[3], img[2], img[1], img[0]};
    exp_kind = (n > 32'd16384) ? 1 : 0;
    if (exp_kind == 0)
      for (int i = 0; i < int'(n); i++) begin
        d = {img[4+4*i+3], img[4+4*i+2], img[4+4*i+1], img[4+4*i]};
        exp_addr.push_back(32'(i * 4));
        exp_data.push_back(d);
        exp_sum += d;
      end
  endtask

  task automatic run_load(input int max_cyc, input int rdy_pct, input int mem_pct);
    bit hold = 0;
    logic [31:0] ha = '0, hd = '0;
    bidx = 0;
    got_addr.delete();
    got_data.delete();
    done_cyc = -1;
    last_wr_cyc = -1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (stop_after >= 0 && bidx >= stop_after) return;
      if (load_completed || load_error) begin
        done_cyc = cyc;
        return;
      end
      if (hold) begin
        tests++;
        if (!inst_mem_in_valid || inst_mem_in_addr !== ha || inst_mem_in_data !== hd) begin
          fails++;
          $display("FAIL stall_stable got v=%b a=%h d=%h exp v=1 a=%h d=%h",
                   inst_mem_in_valid, inst_mem_in_addr, inst_mem_in_data, ha, hd);
        end
      end
      tests++;
      if (uart_out_valid && (inst_mem_in_valid || load_reset)) begin
        fails++;
        $display("FAIL req_exclusive uart_valid=1 mem_valid=%b load_reset=%b exp uart_valid=0",
                 inst_mem_in_valid, load_reset);
      end
      hold = 0;
      if (uart_out_valid) begin
        uart_out_ready = ($urandom_range(99) < rdy_pct) && (bidx < img.size());
        if (uart_out_ready) begin
          uart_out_data = img[bidx];
          bidx++;
        end
      end else begin
        uart_out_ready = 1'($urandom_range(1));
        uart_out_data = 8'($urandom);
      end
      if (inst_mem_in_valid) begin
        if (stall_left > 0) begin
          inst_mem_in_ready = 1'b0;
          stall_left--;
        end else inst_mem_in_ready = ($urandom_range(99) < mem_pct);
        if (inst_mem_in_ready) begin
          got_addr.push_back(inst_mem_in_addr);
          got_data.push_back(inst_mem_in_data);
          last_wr_cyc = cyc;
        end else begin
          hold = 1;
          ha = inst_mem_in_addr;
          hd = inst_mem_in_data;
        end
      end else inst_mem_in_ready = 1'($urandom_range(1));
    end
    tests++;
    fails++;
    $display("FAIL timeout no completion within %0d cycles", max_cyc);
  endtask

  task automatic check_result(input string nm);
    tests++;
    if (got_addr.size() != exp_addr.size()) begin
      fails++;
      $display("FAIL %s write_count got=%0d exp=%0d", nm, got_addr.size(), exp_addr.size());
    end else
      for (int i = 0; i < exp_addr.size(); i++) begin
        tests++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          fails++;
          $display("FAIL %s write[%0d] got=(%h,%h) exp=(%h,%h)", nm, i,
                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    tests++;
    if (checksum !== exp_sum) begin
      fails++;
      $display("FAIL %s checksum got=%h exp=%h", nm, checksum, exp_sum);
    end
    tests++;
    if (load_completed !== (exp_kind == 0) || load_error !== (exp_kind == 1)) begin
      fails++;
      $display("FAIL %s status got done=%b err=%b exp done=%b err=%b", nm,
               load_completed, load_error, exp_kind == 0, exp_kind == 1);
    end
  endtask

  task automatic check_quiet(input string nm, input int n);
    int act = 0;
    int b0 = bidx;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uart_out_ready = 1'b1;
      inst_mem_in_ready = 1'b1;
      if (uart_out_valid || inst_mem_in_valid) act++;
    end
    tests++;
    if (act != 0 || bidx != b0) begin
      fails++;
      $display("FAIL %s quiet got active_cycles=%0d exp=0", nm, act);
    end
  endtask

  task automatic test_reset();
    int cycles = 0;
    do_reset();
    while (load_reset && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
      if (load_reset) begin
        tests++;
        if (uart_out_valid !== 1'b0) begin
          fails++;
          $display("FAIL reset_no_req got uart_valid=%b exp=0 at cycle %0d", uart_out_valid, cycles);
        end
      end
    end
    tests++;
    if (cycles != 10) begin
      fails++;
      $display("FAIL reset_len got=%0d exp=10", cycles);
    end
  endtask

  task automatic test_two_word();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    do_reset();
    build_expected();
    run_load(2000, 60, 100);
    check_result("two_word");
    tests++;
    if (checksum !== 32'h82) begin
      fails++;
      $display("FAIL two_word_sum got=%h exp=00000082", checksum);
    end
    tests++;
    if (done_cyc != last_wr_cyc + 1) begin
      fails++;
      $display("FAIL two_word_done_lat got=%0d exp=%0d", done_cyc, last_wr_cyc + 1);
    end
    check_quiet("two_word", 10);
  endtask

  task automatic test_zero_length();
    img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    build_expected();
    run_load(2000, 70, 100);
    check_result("zero_len");
    check_quiet("zero_len", 10);
  endtask

  task automatic test_oversize();
    img = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    build_expected();
    run_load(2000, 70, 100);
    check_result("oversize");
    check_quiet("oversize", 12);
    tests++;
    if (bidx != 4) begin
      fails++;
      $display("FAIL oversize_bytes got=%0d exp=4", bidx);
    end
  endtask

  task automatic rand_image(input logic [31:0] n, input int words);
    img.delete();
    for (int k = 0; k < 4; k++) img.push_back(8'(n >> (8 * k)));
    for (int k = 0; k < 4 * words; k++) img.push_back(8'($urandom));
  endtask

  task automatic test_backpressure();
    rand_image(32'd3, 3);
    do_reset();
    build_expected();
    stall_left = 5;
    run_load(2000, 80, 100);
    check_result("backpressure");
    tests++;
    if (stall_left != 0) begin
      fails++;
      $display("FAIL backpressure_stall got remaining=%0d exp=0", stall_left);
    end
  endtask

  task automatic test_mid_reset();
    rand_image(32'd3, 3);
    do_reset();
    build_expected();
    stop_after = 6;
    run_load(2000, 100, 100);
    stop_after = -1;
    do_reset();
    run_load(2000, 50, 70);
    check_result("mid_reset");
  endtask

  task automatic test_random();
    logic [31:0] n;
    for (int it = 0; it < 8; it++) begin
      case (it)
        3:       n = 32'hFFFF_FFFF;
        6:       n = 32'd16385 + $urandom_range(1000);
        default: n = 32'($urandom_range(1, 6));
      endcase
      rand_image(n, (n > 32'd16384) ? 1 : int'(n));
      do_reset();
      build_expected();
      run_load(3000, $urandom_range(30, 100), $urandom_range(30, 100));
      check_result($sformatf("random%0d", it));
    end
  endtask

  initial begin
    uart_out_ready = 1'b0;
    uart_out_data = 8'h00;
    inst_mem_in_ready = 1'b0;
    stall_left = 0;
    stop_after = -1;
    test_reset();
    test_two_word();
    test_zero_length();
    test_oversize();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
